// File: rtl/arb_client_pkg.sv
// rtl/arb_client_pkg.sv - shared widths and default depth for the arbiter clients
package arb_client_pkg;

   // Bus word width shared by both clients and the arbiter wrapper
   localparam int ARB_DATA_W = 32;
   // Default FIFO depth per client (power of two, at least 2)
   localparam int ARB_DEPTH  = 4;
   // Width of the transferred-word counter
   localparam int ARB_CNT_W  = 16;

endpackage

// File: rtl/arb_client_fifo.sv
// rtl/arb_client_fifo.sv - synchronous FIFO with registered count and async clear
module arb_client_fifo
   import arb_client_pkg::*;
#(
   parameter int DATA_W = ARB_DATA_W,
   parameter int DEPTH  = ARB_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          push_data_i,
   input  logic                       pop_i,
   output logic [DATA_W-1:0]          head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              do_push, do_pop;

   // Guard locally so a misbehaving caller cannot corrupt the pointers
   assign do_push = push_i && (count_q != FULL_CNT);
   assign do_pop  = pop_i && (count_q != '0);

   // Pointer and occupancy next-state; pointers wrap at DEPTH naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; storage is cleared too so the head reads 0 after reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= push_data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/arb_client_tx.sv
// rtl/arb_client_tx.sv - requester-side client: buffers words, drives req, sends on grant
module arb_client_tx
   import arb_client_pkg::*;
#(
   parameter int DATA_W = ARB_DATA_W,
   parameter int DEPTH  = ARB_DEPTH,
   parameter int CNT_W  = ARB_CNT_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              req,
   input  logic              grant,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic [CNT_W-1:0]  sent_cnt,
   output logic              err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW:0]      count;
   logic             push, pop;
   logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
   logic             err_q, err_d;

   arb_client_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (push),
      .push_data_i (in_data),
      .pop_i       (pop),
      .head_o      (bus_data),
      .count_o     (count)
   );

   // Acceptance uses the registered count only, so a pop at full does not open a slot
   assign in_ready  = (count < FULL_CNT);
   assign push      = in_valid && in_ready;
   assign pop       = grant && (count != '0);
   assign bus_valid = pop;
   // Drop the request while the last buffered word is leaving; grant is a flop, no loop
   assign req       = ((count - {{AW{1'b0}}, pop}) != '0);

   // Counter and sticky error next-state
   always_comb begin
      sent_cnt_d = sent_cnt_q;
      err_d      = err_q;
      if (pop) sent_cnt_d = sent_cnt_q + 1'b1;
      if (grant && (count == '0)) err_d = 1'b1;
   end

   // Counter and error registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sent_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         sent_cnt_q <= sent_cnt_d;
         err_q      <= err_d;
      end
   end

   assign sent_cnt = sent_cnt_q;
   assign err      = err_q;

endmodule
